// File: rtl/rs_sched_if.sv
// Dispatch, CDB and issue bundle for the rs_sched reservation station.
// Field widths come from the shared core width macros; defaults apply when
// no core header has defined them.
`ifndef InstrIdWidth
`define InstrIdWidth 6
`endif
`ifndef ImmWidth
`define ImmWidth 32
`endif
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef ROBIdxWidth
`define ROBIdxWidth 4
`endif
`ifndef WordWidth
`define WordWidth 32
`endif

interface rs_sched_if;
    // dispatch
    logic                      disp_en_in;
    logic [`InstrIdWidth-1:0]  disp_instr_id_in;
    logic [`ImmWidth-1:0]      disp_imm_in;
    logic [`AddrWidth-1:0]     disp_pc_in;
    logic [`ROBIdxWidth-1:0]   disp_rob_pos_in;
    logic [`WordWidth-1:0]     disp_vj_in;
    logic [`WordWidth-1:0]     disp_vk_in;
    logic                      disp_qj_rdy_in;
    logic                      disp_qk_rdy_in;
    logic [`ROBIdxWidth-1:0]   disp_qj_in;
    logic [`ROBIdxWidth-1:0]   disp_qk_in;
    logic                      full_out;
    // result broadcast
    logic                      alu_cdb_en_in;
    logic [`ROBIdxWidth-1:0]   alu_cdb_rob_pos_in;
    logic [`WordWidth-1:0]     alu_cdb_res_in;
    logic                      lsb_cdb_en_in;
    logic [`ROBIdxWidth-1:0]   lsb_cdb_rob_pos_in;
    logic [`WordWidth-1:0]     lsb_cdb_res_in;
    // issue
    logic                      rs_to_ex_en_out;
    logic [`InstrIdWidth-1:0]  ex_instr_id_out;
    logic [`ImmWidth-1:0]      ex_imm_out;
    logic [`WordWidth-1:0]     ex_rs1_out;
    logic [`WordWidth-1:0]     ex_rs2_out;
    logic [`AddrWidth-1:0]     ex_pc_out;
    logic [`ROBIdxWidth-1:0]   ex_rob_pos_out;

    modport master (
        output disp_en_in, disp_instr_id_in, disp_imm_in, disp_pc_in, disp_rob_pos_in,
               disp_vj_in, disp_vk_in, disp_qj_rdy_in, disp_qk_rdy_in, disp_qj_in, disp_qk_in,
               alu_cdb_en_in, alu_cdb_rob_pos_in, alu_cdb_res_in,
               lsb_cdb_en_in, lsb_cdb_rob_pos_in, lsb_cdb_res_in,
        input  full_out, rs_to_ex_en_out, ex_instr_id_out, ex_imm_out,
               ex_rs1_out, ex_rs2_out, ex_pc_out, ex_rob_pos_out
    );

    modport slave (
        input  disp_en_in, disp_instr_id_in, disp_imm_in, disp_pc_in, disp_rob_pos_in,
               disp_vj_in, disp_vk_in, disp_qj_rdy_in, disp_qk_rdy_in, disp_qj_in, disp_qk_in,
               alu_cdb_en_in, alu_cdb_rob_pos_in, alu_cdb_res_in,
               lsb_cdb_en_in, lsb_cdb_rob_pos_in, lsb_cdb_res_in,
        output full_out, rs_to_ex_en_out, ex_instr_id_out, ex_imm_out,
               ex_rs1_out, ex_rs2_out, ex_pc_out, ex_rob_pos_out
    );
endinterface

// File: rtl/rs_sched.sv
// rs_sched: reservation station with CDB wakeup and single issue per cycle.
// Optional macro RS_AGE_SELECT_EN: keep a DEPTH x DEPTH age matrix and issue
// the oldest ready entry; otherwise the lowest-index ready entry issues.
module rs_sched #(
    parameter int DEPTH = 8
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      clr_in,
    rs_sched_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                     busy;
        logic [`InstrIdWidth-1:0] instr_id;
        logic [`ImmWidth-1:0]     imm;
        logic [`AddrWidth-1:0]    pc;
        logic [`ROBIdxWidth-1:0]  rob_pos;
        logic [`WordWidth-1:0]    vj;
        logic [`WordWidth-1:0]    vk;
        logic [`ROBIdxWidth-1:0]  qj;
        logic [`ROBIdxWidth-1:0]  qk;
        logic                     rj;
        logic                     rk;
    } entry_t;

    entry_t [DEPTH-1:0]       ent_q, ent_d;
    entry_t                   disp_ent;
    logic [DEPTH-1:0]         busy_vec, ready_vec;
    logic                     full;
    logic                     disp_fire;
    logic [IDX_W-1:0]         free_idx;
    logic                     sel_vld;
    logic [IDX_W-1:0]         sel_idx;

    logic                     en_q, en_d;
    logic [`InstrIdWidth-1:0] ex_id_q, ex_id_d;
    logic [`ImmWidth-1:0]     ex_imm_q, ex_imm_d;
    logic [`WordWidth-1:0]    ex_rs1_q, ex_rs1_d;
    logic [`WordWidth-1:0]    ex_rs2_q, ex_rs2_d;
    logic [`AddrWidth-1:0]    ex_pc_q, ex_pc_d;
    logic [`ROBIdxWidth-1:0]  ex_rob_q, ex_rob_d;

`ifdef RS_AGE_SELECT_EN
    // age_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
`endif

    // readiness, free slot and fullness all come from registered state only
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_vec[i]) free_idx = IDX_W'(i);
        end
        full      = &busy_vec;
        disp_fire = bus.disp_en_in & ~full;
    end

`ifdef RS_AGE_SELECT_EN
    // pick the ready entry that no other ready entry is older than
    always_comb begin
        logic older;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            older = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready_vec[j] && age_q[j][i]) older = 1'b1;
            end
            if (ready_vec[i] && !older) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
`else
    // pick the lowest-index ready entry
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    // build the incoming entry, snooping both CDB ports for pending operands
    always_comb begin
        disp_ent          = '0;
        disp_ent.busy     = 1'b1;
        disp_ent.instr_id = bus.disp_instr_id_in;
        disp_ent.imm      = bus.disp_imm_in;
        disp_ent.pc       = bus.disp_pc_in;
        disp_ent.rob_pos  = bus.disp_rob_pos_in;
        disp_ent.vj       = bus.disp_vj_in;
        disp_ent.vk       = bus.disp_vk_in;
        disp_ent.qj       = bus.disp_qj_in;
        disp_ent.qk       = bus.disp_qk_in;
        disp_ent.rj       = bus.disp_qj_rdy_in;
        disp_ent.rk       = bus.disp_qk_rdy_in;
        if (!bus.disp_qj_rdy_in) begin
            if (bus.alu_cdb_en_in && bus.alu_cdb_rob_pos_in == bus.disp_qj_in) begin
                disp_ent.vj = bus.alu_cdb_res_in;
                disp_ent.rj = 1'b1;
            end else if (bus.lsb_cdb_en_in && bus.lsb_cdb_rob_pos_in == bus.disp_qj_in) begin
                disp_ent.vj = bus.lsb_cdb_res_in;
                disp_ent.rj = 1'b1;
            end
        end
        if (!bus.disp_qk_rdy_in) begin
            if (bus.alu_cdb_en_in && bus.alu_cdb_rob_pos_in == bus.disp_qk_in) begin
                disp_ent.vk = bus.alu_cdb_res_in;
                disp_ent.rk = 1'b1;
            end else if (bus.lsb_cdb_en_in && bus.lsb_cdb_rob_pos_in == bus.disp_qk_in) begin
                disp_ent.vk = bus.lsb_cdb_res_in;
                disp_ent.rk = 1'b1;
            end
        end
    end

    // next state: flush beats everything, rdy low freezes, else wakeup/issue/dispatch
    always_comb begin
        ent_d    = ent_q;
        en_d     = 1'b0;
        ex_id_d  = ex_id_q;
        ex_imm_d = ex_imm_q;
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        ex_pc_d  = ex_pc_q;
        ex_rob_d = ex_rob_q;
        if (clr_in) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].busy && !ent_q[i].rj) begin
                    if (bus.alu_cdb_en_in && ent_q[i].qj == bus.alu_cdb_rob_pos_in) begin
                        ent_d[i].vj = bus.alu_cdb_res_in;
                        ent_d[i].rj = 1'b1;
                    end else if (bus.lsb_cdb_en_in && ent_q[i].qj == bus.lsb_cdb_rob_pos_in) begin
                        ent_d[i].vj = bus.lsb_cdb_res_in;
                        ent_d[i].rj = 1'b1;
                    end
                end
                if (ent_q[i].busy && !ent_q[i].rk) begin
                    if (bus.alu_cdb_en_in && ent_q[i].qk == bus.alu_cdb_rob_pos_in) begin
                        ent_d[i].vk = bus.alu_cdb_res_in;
                        ent_d[i].rk = 1'b1;
                    end else if (bus.lsb_cdb_en_in && ent_q[i].qk == bus.lsb_cdb_rob_pos_in) begin
                        ent_d[i].vk = bus.lsb_cdb_res_in;
                        ent_d[i].rk = 1'b1;
                    end
                end
            end
            if (sel_vld) begin
                en_d                = 1'b1;
                ex_id_d             = ent_q[sel_idx].instr_id;
                ex_imm_d            = ent_q[sel_idx].imm;
                ex_rs1_d            = ent_q[sel_idx].vj;
                ex_rs2_d            = ent_q[sel_idx].vk;
                ex_pc_d             = ent_q[sel_idx].pc;
                ex_rob_d            = ent_q[sel_idx].rob_pos;
                ent_d[sel_idx].busy = 1'b0;
            end
            // free_idx never points at the issuing slot, so reuse waits a cycle
            if (disp_fire) ent_d[free_idx] = disp_ent;
        end
    end

`ifdef RS_AGE_SELECT_EN
    // a newly dispatched entry is younger than every other slot
    always_comb begin
        age_d = age_q;
        if (!clr_in && rdy_in && disp_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_d[free_idx][j] = 1'b0;
                age_d[j][free_idx] = 1'b1;
            end
            age_d[free_idx][free_idx] = 1'b0;
        end
    end

    // age matrix register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) age_q <= '0;
        else         age_q <= age_d;
    end
`endif

    // entry and issue registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ent_q    <= '0;
            en_q     <= 1'b0;
            ex_id_q  <= '0;
            ex_imm_q <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_pc_q  <= '0;
            ex_rob_q <= '0;
        end else begin
            ent_q    <= ent_d;
            en_q     <= en_d;
            ex_id_q  <= ex_id_d;
            ex_imm_q <= ex_imm_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            ex_pc_q  <= ex_pc_d;
            ex_rob_q <= ex_rob_d;
        end
    end

    assign bus.full_out        = full;
    assign bus.rs_to_ex_en_out = en_q;
    assign bus.ex_instr_id_out = ex_id_q;
    assign bus.ex_imm_out      = ex_imm_q;
    assign bus.ex_rs1_out      = ex_rs1_q;
    assign bus.ex_rs2_out      = ex_rs2_q;
    assign bus.ex_pc_out       = ex_pc_q;
    assign bus.ex_rob_pos_out  = ex_rob_q;
endmodule

// File: tb/tb_rs_sched.sv
// Bench for rs_sched: directed scenarios then random traffic, checked against
// an entry-list model that orders entries by a dispatch sequence number.
`ifndef InstrIdWidth
`define InstrIdWidth 6
`endif
`ifndef ImmWidth
`define ImmWidth 32
`endif
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef ROBIdxWidth
`define ROBIdxWidth 4
`endif
`ifndef WordWidth
`define WordWidth 32
`endif

module tb_rs_sched;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rs_sched_if bus ();

    rs_sched #(.DEPTH(DEPTH)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .clr_in (clr),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy, rj, rk;
        logic [31:0] vj, vk, imm, pc;
        logic [7:0]  id, qj, qk, rob;
        int        seq;
    } ent_t;

    ent_t        m [DEPTH];
    int          seq_ctr = 0;
    bit          e_en;
    logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
    logic [7:0]  e_id, e_rob;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
        e_en = 0; e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_pc = 0; e_id = 0; e_rob = 0;
    endtask

    function automatic bit m_full();
        for (int i = 0; i < DEPTH; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // resolve a pending tag against the two broadcast ports
    task automatic snoop(input logic [7:0] tag, inout bit r, inout logic [31:0] v);
        if (r) return;
        if (bus.alu_cdb_en_in && 8'(bus.alu_cdb_rob_pos_in) == tag) begin
            r = 1; v = bus.alu_cdb_res_in;
        end else if (bus.lsb_cdb_en_in && 8'(bus.lsb_cdb_rob_pos_in) == tag) begin
            r = 1; v = bus.lsb_cdb_res_in;
        end
    endtask

    // what one clock edge does to the entry list, given the current inputs
    task automatic model_edge();
        ent_t nx [DEPTH];
        int   sel = -1;
        int   f = -1;
        bit   full = m_full();
        nx = m;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) nx[i].busy = 0;
            e_en = 0;
        end else if (!rdy) begin
            e_en = 0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].busy && m[i].rj && m[i].rk) begin
`ifdef RS_AGE_SELECT_EN
                    if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
            e_en = (sel >= 0);
            if (sel >= 0) begin
                e_id = m[sel].id; e_imm = m[sel].imm; e_pc = m[sel].pc;
                e_rs1 = m[sel].vj; e_rs2 = m[sel].vk; e_rob = m[sel].rob;
                nx[sel].busy = 0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].busy) begin
                    snoop(m[i].qj, nx[i].rj, nx[i].vj);
                    snoop(m[i].qk, nx[i].rk, nx[i].vk);
                end
            end
            if (bus.disp_en_in && !full) begin
                for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].busy) f = i;
                nx[f].busy = 1;
                nx[f].id = 8'(bus.disp_instr_id_in);
                nx[f].imm = bus.disp_imm_in;
                nx[f].pc = bus.disp_pc_in;
                nx[f].rob = 8'(bus.disp_rob_pos_in);
                nx[f].qj = 8'(bus.disp_qj_in);
                nx[f].qk = 8'(bus.disp_qk_in);
                nx[f].vj = bus.disp_vj_in;
                nx[f].vk = bus.disp_vk_in;
                nx[f].rj = bus.disp_qj_rdy_in;
                nx[f].rk = bus.disp_qk_rdy_in;
                nx[f].seq = seq_ctr++;
                snoop(nx[f].qj, nx[f].rj, nx[f].vj);
                snoop(nx[f].qk, nx[f].rk, nx[f].vk);
            end
        end
        m = nx;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_en"}, 64'(bus.rs_to_ex_en_out), 64'(e_en));
        chk({tag, "_id"}, 64'(bus.ex_instr_id_out), 64'(e_id));
        chk({tag, "_imm"}, 64'(bus.ex_imm_out), 64'(e_imm));
        chk({tag, "_rs1"}, 64'(bus.ex_rs1_out), 64'(e_rs1));
        chk({tag, "_rs2"}, 64'(bus.ex_rs2_out), 64'(e_rs2));
        chk({tag, "_pc"}, 64'(bus.ex_pc_out), 64'(e_pc));
        chk({tag, "_rob"}, 64'(bus.ex_rob_pos_out), 64'(e_rob));
    endtask

    // one clock: check full, advance model, clock, check outputs, drop pulses
    task automatic step(input string tag);
        chk({tag, "_full"}, 64'(bus.full_out), 64'(m_full()));
        model_edge();
        @(posedge clk);
        #1;
        check_outs(tag);
        bus.disp_en_in = 0; bus.alu_cdb_en_in = 0; bus.lsb_cdb_en_in = 0; clr = 0;
    endtask

    task automatic disp(input int id, input int imm, input int pc, input int rob,
                        input int vj, input int vk, input bit qjr, input bit qkr,
                        input int qj, input int qk);
        logic [31:0] t;
        bus.disp_en_in = 1;
        t = id;  bus.disp_instr_id_in = t[`InstrIdWidth-1:0];
        bus.disp_imm_in = imm; bus.disp_pc_in = pc;
        t = rob; bus.disp_rob_pos_in = t[`ROBIdxWidth-1:0];
        bus.disp_vj_in = vj; bus.disp_vk_in = vk;
        bus.disp_qj_rdy_in = qjr; bus.disp_qk_rdy_in = qkr;
        t = qj;  bus.disp_qj_in = t[`ROBIdxWidth-1:0];
        t = qk;  bus.disp_qk_in = t[`ROBIdxWidth-1:0];
    endtask

    task automatic alu(input int pos, input int res);
        logic [31:0] t = pos;
        bus.alu_cdb_en_in = 1; bus.alu_cdb_rob_pos_in = t[`ROBIdxWidth-1:0];
        bus.alu_cdb_res_in = res;
    endtask

    task automatic lsb(input int pos, input int res);
        logic [31:0] t = pos;
        bus.lsb_cdb_en_in = 1; bus.lsb_cdb_rob_pos_in = t[`ROBIdxWidth-1:0];
        bus.lsb_cdb_res_in = res;
    endtask

    initial begin
        logic [31:0] r;
        bus.disp_en_in = 0; bus.alu_cdb_en_in = 0; bus.lsb_cdb_en_in = 0;
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.disp_en_in = 0;
        alu(0, 0); lsb(0, 0);
        bus.alu_cdb_en_in = 0; bus.lsb_cdb_en_in = 0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst");
        chk("rst_full", 64'(bus.full_out), 64'd0);
        rst_n = 1;

        // ready ADDI issues two edges after being presented, for one cycle
        disp(8'h13, 3, 32'h100, 2, 5, 0, 1, 1, 0, 0);
        step("addi_d");
        chk("addi_noearly", 64'(bus.rs_to_ex_en_out), 64'd0);
        step("addi_i");
        chk("addi_en", 64'(bus.rs_to_ex_en_out), 64'd1);
        chk("addi_rs1", 64'(bus.ex_rs1_out), 64'd5);
        chk("addi_imm", 64'(bus.ex_imm_out), 64'd3);
        chk("addi_rob", 64'(bus.ex_rob_pos_out), 64'd2);
        step("addi_one");

        // ADD waits on tag 4 until the ALU broadcasts it
        disp(8'h33, 0, 32'h104, 3, 0, 22, 0, 1, 4, 0);
        step("add_d");
        step("add_w1");
        step("add_w2");
        alu(4, 32'h10);
        step("add_wk");
        chk("add_notyet", 64'(bus.rs_to_ex_en_out), 64'd0);
        step("add_i");
        chk("add_rs1", 64'(bus.ex_rs1_out), 64'h10);

        // dispatch-time snoop on the LSB port
        disp(8'h33, 0, 32'h108, 6, 1, 0, 1, 0, 0, 7);
        lsb(7, 9);
        step("snp_d");
        step("snp_i");
        chk("snp_rs2", 64'(bus.ex_rs2_out), 64'd9);

        // fill all slots with waiting entries; ninth dispatch dropped
        for (int i = 0; i < DEPTH; i++) begin
            disp(i, i, i, 8 + i, 0, 0, 0, 1, i, 0);
            step("fill");
        end
        chk("fill_full", 64'(bus.full_out), 64'd1);
        disp(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        step("fill_drop");
        step("fill_drop2");
        chk("fill_dropped", 64'(bus.rs_to_ex_en_out), 64'd0);
        alu(3, 32'h33);
        step("fill_wake");
        disp(2, 2, 2, 2, 2, 2, 1, 1, 0, 0);  // arrives on the issue edge: still full
        step("fill_iss");
        chk("fill_free", 64'(bus.full_out), 64'd0);
        step("fill_post");
        clr = 1;
        step("fill_clr");

        // slot 5 dispatched before a fresh slot 1, both woken together
        for (int i = 0; i < DEPTH; i++) begin
            disp(i, 0, 0, (i == 5) ? 5 : 9, 0, 0, 0, 1, (i == 1) ? 11 : (i == 5) ? 12 : 10, 0);
            step("age_f");
        end
        alu(11, 1);
        step("age_w1");
        step("age_i1");
        disp(7, 0, 0, 1, 0, 0, 0, 1, 12, 0);
        step("age_d1");
        alu(12, 32'h55);
        step("age_wk");
        step("age_a");
`ifdef RS_AGE_SELECT_EN
        chk("age_first", 64'(bus.ex_rob_pos_out), 64'd5);
`else
        chk("age_first", 64'(bus.ex_rob_pos_out), 64'd1);
`endif
        step("age_b");
`ifdef RS_AGE_SELECT_EN
        chk("age_second", 64'(bus.ex_rob_pos_out), 64'd1);
`else
        chk("age_second", 64'(bus.ex_rob_pos_out), 64'd5);
`endif
        clr = 1;
        step("age_clr");

        // flush with three busy entries, one of them ready
        disp(1, 0, 0, 1, 0, 0, 0, 1, 9, 0); step("cl_a");
        disp(2, 0, 0, 2, 0, 0, 0, 1, 9, 0); step("cl_b");
        disp(3, 0, 0, 3, 7, 7, 1, 1, 0, 0); step("cl_c");
        clr = 1;
        step("cl_flush");
        chk("cl_noiss", 64'(bus.rs_to_ex_en_out), 64'd0);
        chk("cl_full", 64'(bus.full_out), 64'd0);
        alu(9, 4);
        step("cl_after");
        step("cl_after2");

        // asynchronous reset in the middle of activity
        disp(4, 4, 4, 4, 4, 4, 1, 1, 0, 0); step("mr_a");
        disp(5, 5, 5, 5, 5, 5, 1, 1, 0, 0); step("mr_b");
        #2 rst_n = 0;
        #1;
        chk("mr_en", 64'(bus.rs_to_ex_en_out), 64'd0);
        chk("mr_full", 64'(bus.full_out), 64'd0);
        chk("mr_rs1", 64'(bus.ex_rs1_out), 64'd0);
        model_reset();
        #1 rst_n = 1;
        step("mr_q1");
        step("mr_q2");

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom();
            if (r[3:0] < 10) disp($urandom(), $urandom(), $urandom(), $urandom(),
                                  $urandom(), $urandom(), r[4], r[5],
                                  $urandom_range(15, 0), $urandom_range(15, 0));
            if (r[8:6] < 3) alu($urandom_range(15, 0), $urandom());
            if (r[11:9] < 3) lsb($urandom_range(15, 0), $urandom());
            if (bus.alu_cdb_en_in && bus.lsb_cdb_en_in &&
                bus.alu_cdb_rob_pos_in == bus.lsb_cdb_rob_pos_in) bus.lsb_cdb_en_in = 0;
            clr = (r[18:12] == 0);
            rdy = (r[22:19] != 0);
            step("rnd");
        end
        rdy = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
